// File: rtl/pipe_mips32_pkg.sv
// Shared opcodes, instruction classes and pipeline latch layouts for pipe_mips32.
package pipe_mips32_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // OR R0,R0,R0
    localparam logic [31:0] NOP_INSTR = 32'h0C00_0000;

    typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT} instr_type_e;

    typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluMul} alu_op_e;

    typedef struct packed {
        instr_type_e itype;
        alu_op_e     alu_op;
        logic        reg_we;
        logic        use_imm;
    } decode_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } if_id_t;

    typedef struct packed {
        decode_t     dec;
        logic        beqz;
        logic [4:0]  dest;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } id_ex_t;

    typedef struct packed {
        instr_type_e itype;
        logic        reg_we;
        logic [4:0]  dest;
        logic [31:0] aluout;
        logic [31:0] b;
        logic        cond;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_we;
        logic        halt;
        logic [4:0]  dest;
        logic [31:0] result;
    } mem_wb_t;

    // Bubbles carry no write-enables so they can never disturb state.
    localparam decode_t NOP_DEC = '{itype: RR_ALU, alu_op: AluOr, reg_we: 1'b0, use_imm: 1'b0};
    localparam if_id_t  IF_ID_NOP = '{ir: NOP_INSTR, npc: 32'd0};
    localparam id_ex_t  ID_EX_NOP = '{dec: NOP_DEC, beqz: 1'b0, dest: 5'd0, npc: 32'd0,
                                      a: 32'd0, b: 32'd0, imm: 32'd0};
    localparam ex_mem_t EX_MEM_NOP = '{itype: RR_ALU, reg_we: 1'b0, dest: 5'd0,
                                       aluout: 32'd0, b: 32'd0, cond: 1'b0};
    localparam mem_wb_t MEM_WB_NOP = '{reg_we: 1'b0, halt: 1'b0, dest: 5'd0, result: 32'd0};

    // Undefined opcodes fall through as register ops with no write-enable.
    function automatic decode_t decode(input logic [5:0] op);
        decode_t d;
        d.itype   = RR_ALU;
        d.alu_op  = AluAdd;
        d.reg_we  = 1'b0;
        d.use_imm = 1'b0;
        case (op)
            OP_ADD:  d.reg_we = 1'b1;
            OP_SUB:  begin d.alu_op = AluSub; d.reg_we = 1'b1; end
            OP_AND:  begin d.alu_op = AluAnd; d.reg_we = 1'b1; end
            OP_OR:   begin d.alu_op = AluOr;  d.reg_we = 1'b1; end
            OP_SLT:  begin d.alu_op = AluSlt; d.reg_we = 1'b1; end
            OP_MUL:  begin d.alu_op = AluMul; d.reg_we = 1'b1; end
            OP_ADDI: begin d.itype = RM_ALU; d.use_imm = 1'b1; d.reg_we = 1'b1; end
            OP_SUBI: begin
                d.itype = RM_ALU; d.alu_op = AluSub; d.use_imm = 1'b1; d.reg_we = 1'b1;
            end
            OP_SLTI: begin
                d.itype = RM_ALU; d.alu_op = AluSlt; d.use_imm = 1'b1; d.reg_we = 1'b1;
            end
            OP_LW:   begin d.itype = LOAD; d.use_imm = 1'b1; d.reg_we = 1'b1; end
            OP_SW:   begin d.itype = STORE; d.use_imm = 1'b1; end
            OP_BNEQZ, OP_BEQZ: begin d.itype = BRANCH; d.use_imm = 1'b1; end
            OP_HLT:  d.itype = HALT;
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pipe_mips32_alu.sv
// Combinational 32-bit ALU used by the EX stage.
module pipe_mips32_alu
    import pipe_mips32_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    // Select the operation result; arithmetic wraps at 32 bits.
    always_comb begin
        y = 32'd0;
        unique case (op)
            AluAdd:  y = a + b;
            AluSub:  y = a - b;
            AluAnd:  y = a & b;
            AluOr:   y = a | b;
            AluSlt:  y = {31'd0, $signed(a) < $signed(b)};
            AluMul:  y = a * b;
            default: y = 32'd0;
        endcase
    end

endmodule

// File: rtl/pipe_mips32.sv
// Five-stage MIPS32-subset core with unified word memory, partial bypass and branch squash.
module pipe_mips32
    import pipe_mips32_pkg::*;
(
    input logic clk1,
    input logic rst
);

    logic [31:0] Reg [0:31];
    logic [31:0] Mem [0:1023];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;

    if_id_t  if_id_q;
    id_ex_t  id_ex_q;
    ex_mem_t ex_mem_q;
    mem_wb_t mem_wb_q;
    logic    fetch_stop_q;

    logic [4:0]  rs, rt, rd, id_dest;
    decode_t     id_dec;
    logic [31:0] id_imm, mem_val, opa, opb;
    logic [31:0] alu_a, alu_b, alu_y;
    logic        ex_cond, taken;

    assign rs      = if_id_q.ir[25:21];
    assign rt      = if_id_q.ir[20:16];
    assign rd      = if_id_q.ir[15:11];
    assign id_dec  = decode(if_id_q.ir[31:26]);
    assign id_imm  = {{16{if_id_q.ir[15]}}, if_id_q.ir[15:0]};
    assign id_dest = (id_dec.itype == RR_ALU) ? rd : rt;

    // MEM-stage result: load data read combinationally, else the ALU value.
    assign mem_val = (ex_mem_q.itype == LOAD) ? Mem[ex_mem_q.aluout[9:0]] : ex_mem_q.aluout;

    // Operand read with MEM bypass, then WB write-through, then the register file.
    always_comb begin
        if (rs == 5'd0) opa = 32'd0;
        else if (ex_mem_q.reg_we && ex_mem_q.dest == rs) opa = mem_val;
        else if (mem_wb_q.reg_we && mem_wb_q.dest == rs) opa = mem_wb_q.result;
        else opa = Reg[rs];
        if (rt == 5'd0) opb = 32'd0;
        else if (ex_mem_q.reg_we && ex_mem_q.dest == rt) opb = mem_val;
        else if (mem_wb_q.reg_we && mem_wb_q.dest == rt) opb = mem_wb_q.result;
        else opb = Reg[rt];
    end

    // Branches compute their target as npc + imm on the ALU.
    assign alu_a   = (id_ex_q.dec.itype == BRANCH) ? id_ex_q.npc : id_ex_q.a;
    assign alu_b   = id_ex_q.dec.use_imm ? id_ex_q.imm : id_ex_q.b;
    assign ex_cond = id_ex_q.beqz ? (id_ex_q.a == 32'd0) : (id_ex_q.a != 32'd0);

    pipe_mips32_alu u_alu (
        .op (id_ex_q.dec.alu_op),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    assign taken        = (ex_mem_q.itype == BRANCH) && ex_mem_q.cond;
    assign TAKEN_BRANCH = taken && !HALTED;

    // Pipeline latches, PC and halt control; everything freezes once HALTED.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            PC           <= 32'd0;
            HALTED       <= 1'b0;
            fetch_stop_q <= 1'b0;
            if_id_q      <= IF_ID_NOP;
            id_ex_q      <= ID_EX_NOP;
            ex_mem_q     <= EX_MEM_NOP;
            mem_wb_q     <= MEM_WB_NOP;
        end else if (!HALTED) begin
            // A taken branch overrides a HLT that is itself on the wrong path.
            if (taken) begin
                if_id_q      <= '{ir: Mem[ex_mem_q.aluout[9:0]], npc: ex_mem_q.aluout + 32'd1};
                PC           <= ex_mem_q.aluout + 32'd1;
                fetch_stop_q <= 1'b0;
            end else if (fetch_stop_q || id_dec.itype == HALT) begin
                if_id_q      <= IF_ID_NOP;
                fetch_stop_q <= 1'b1;
            end else begin
                if_id_q <= '{ir: Mem[PC[9:0]], npc: PC + 32'd1};
                PC      <= PC + 32'd1;
            end

            if (taken) begin
                id_ex_q  <= ID_EX_NOP;
                ex_mem_q <= EX_MEM_NOP;
            end else begin
                id_ex_q  <= '{dec: id_dec, beqz: (if_id_q.ir[31:26] == OP_BEQZ),
                              dest: id_dest, npc: if_id_q.npc, a: opa, b: opb, imm: id_imm};
                ex_mem_q <= '{itype: id_ex_q.dec.itype, reg_we: id_ex_q.dec.reg_we,
                              dest: id_ex_q.dest, aluout: alu_y, b: id_ex_q.b, cond: ex_cond};
            end

            mem_wb_q <= '{reg_we: ex_mem_q.reg_we, halt: (ex_mem_q.itype == HALT),
                          dest: ex_mem_q.dest, result: mem_val};

            if (mem_wb_q.halt) HALTED <= 1'b1;
        end
    end

    // Architectural writes; reset empties the latches so nothing is written during rst.
    always_ff @(posedge clk1) begin
        if (!HALTED) begin
            if (mem_wb_q.reg_we && mem_wb_q.dest != 5'd0) Reg[mem_wb_q.dest] <= mem_wb_q.result;
            if (ex_mem_q.itype == STORE) Mem[ex_mem_q.aluout[9:0]] <= ex_mem_q.b;
        end
    end

endmodule

// File: tb/tb_pipe_mips32.sv
// Scoreboard bench for pipe_mips32: directed programs, expectations checked at halt.
module tb_pipe_mips32;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;

    always #5 clk1 = ~clk1;

    pipe_mips32 dut (
        .clk1 (clk1),
        .rst  (rst)
    );

    typedef enum {KReg, KMem, KPc, KHalted, KTaken} kind_e;
    typedef struct {
        string       name;
        kind_e       kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   taken_count = 0;
    logic armed = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic logic [31:0] actual(exp_t e);
        case (e.kind)
            KReg:    return dut.Reg[e.idx];
            KMem:    return dut.Mem[e.idx];
            KPc:     return dut.PC;
            KHalted: return {31'd0, dut.HALTED};
            default: return 32'(taken_count);
        endcase
    endfunction

    task automatic expect_val(string name, kind_e k, int idx, logic [31:0] v);
        exp_t e;
        e.name = name; e.kind = k; e.idx = idx; e.exp = v;
        exp_q.push_back(e);
    endtask

    task automatic put(int a, logic [31:0] w);
        dut.Mem[a] = w;
    endtask

    task automatic run_prog();
        rst   = 1'b0;
        armed = 1'b1;
        wait (!armed);
    endtask

    // Count TAKEN_BRANCH cycles.
    always @(negedge clk1) if (!rst && dut.TAKEN_BRANCH) taken_count++;

    // Monitor: when the core halts (bounded wait), drain and compare all expectations.
    initial begin
        forever begin
            int n;
            wait (armed);
            n = 0;
            @(negedge clk1);
            while (!dut.HALTED && n < 100) begin
                @(negedge clk1);
                n++;
            end
            check("halt_within_budget", {31'd0, dut.HALTED}, 32'd1);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, actual(e), e.exp);
            end
            armed = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Main program
        rst = 1'b1;
        for (int k = 0; k < 32; k++) dut.Reg[k] = k;
        put(0, 32'h2801000a); put(1, 32'h28020014); put(2, 32'h28030019);
        put(3, 32'h0ce77800); put(4, 32'h0ce77800); put(5, 32'h00222000);
        put(6, 32'h0ce77800); put(7, 32'h00832800); put(8, 32'hfc000000);
        repeat (2) @(negedge clk1);
        check("reset_pc", dut.PC, 32'd0);
        check("reset_halted", {31'd0, dut.HALTED}, 32'd0);
        check("reset_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
        expect_val("main_r1", KReg, 1, 32'd10);
        expect_val("main_r2", KReg, 2, 32'd20);
        expect_val("main_r3", KReg, 3, 32'd25);
        expect_val("main_r4", KReg, 4, 32'd30);
        expect_val("main_r5", KReg, 5, 32'd55);
        expect_val("main_r0", KReg, 0, 32'd0);
        expect_val("main_halted", KHalted, 0, 32'd1);
        expect_val("main_pc", KPc, 0, 32'd9);
        run_prog();

        // Distance-2 bypass
        rst = 1'b1;
        dut.Reg[1] = 32'd100; dut.Reg[2] = 32'd0;
        put(0, 32'h28010007); put(1, 32'h0c000000); put(2, 32'h00211000); put(3, 32'hfc000000);
        @(negedge clk1);
        check("rst_clears_halted", {31'd0, dut.HALTED}, 32'd0);
        expect_val("byp_r1", KReg, 1, 32'd7);
        expect_val("byp_r2", KReg, 2, 32'd14);
        run_prog();

        // Load / add / store through bypass
        rst = 1'b1;
        dut.Reg[1] = 32'd120; dut.Reg[2] = 32'd0;
        put(120, 32'd85); put(121, 32'd0);
        put(0, 32'h20220000); put(1, 32'h0c000000); put(2, 32'h2842002d);
        put(3, 32'h0c000000); put(4, 32'h24220001); put(5, 32'hfc000000);
        @(negedge clk1);
        expect_val("ls_mem121", KMem, 121, 32'd130);
        expect_val("ls_r2", KReg, 2, 32'd130);
        expect_val("ls_mem120", KMem, 120, 32'd85);
        run_prog();

        // Not-taken BNEQZ, then taken BEQZ over two ADDIs
        rst = 1'b1;
        dut.Reg[8] = 32'd0; dut.Reg[9] = 32'h99;
        put(0, 32'h34000005); put(1, 32'h38000002); put(2, 32'h28090001);
        put(3, 32'h28090002); put(4, 32'h28080005); put(5, 32'hfc000000);
        @(negedge clk1);
        taken_count = 0;
        expect_val("br_r9_unchanged", KReg, 9, 32'h99);
        expect_val("br_r8", KReg, 8, 32'd5);
        expect_val("br_taken_pulses", KTaken, 0, 32'd1);
        expect_val("br_pc", KPc, 0, 32'd6);
        run_prog();

        // HALT freeze: SW after HLT must never execute; R0 write discarded
        rst = 1'b1;
        dut.Reg[6] = 32'd0;
        put(50, 32'hdeadbeef);
        put(0, 32'h28060003); put(1, 32'h28000009); put(2, 32'hfc000000); put(3, 32'h24060032);
        @(negedge clk1);
        expect_val("hlt_r6", KReg, 6, 32'd3);
        expect_val("hlt_r0", KReg, 0, 32'd0);
        expect_val("hlt_mem50", KMem, 50, 32'hdeadbeef);
        expect_val("hlt_pc", KPc, 0, 32'd3);
        run_prog();
        repeat (10) @(negedge clk1);
        check("hlt_pc_frozen", dut.PC, 32'd3);
        check("hlt_mem50_frozen", dut.Mem[50], 32'hdeadbeef);
        check("hlt_still_halted", {31'd0, dut.HALTED}, 32'd1);

        // Mid-program reset, then rerun to completion
        rst = 1'b1;
        for (int k = 1; k < 6; k++) dut.Reg[k] = 32'd0;
        put(0, 32'h2801000a); put(1, 32'h28020014); put(2, 32'h28030019);
        put(3, 32'h0ce77800); put(4, 32'h0ce77800); put(5, 32'h00222000);
        put(6, 32'h0ce77800); put(7, 32'h00832800); put(8, 32'hfc000000);
        @(negedge clk1);
        rst = 1'b0;
        repeat (6) @(negedge clk1);
        rst = 1'b1;
        #1;
        check("midrst_pc", dut.PC, 32'd0);
        check("midrst_halted", {31'd0, dut.HALTED}, 32'd0);
        @(negedge clk1);
        check("midrst_r4_unwritten", dut.Reg[4], 32'd0);
        expect_val("rerun_r1", KReg, 1, 32'd10);
        expect_val("rerun_r4", KReg, 4, 32'd30);
        expect_val("rerun_r5", KReg, 5, 32'd55);
        expect_val("rerun_pc", KPc, 0, 32'd9);
        run_prog();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_mips32.md
# pipe_mips32

Five-stage pipelined MIPS32-subset processor (IF, ID, EX, MEM, WB) with an internal unified word-addressed instruction/data memory and a 32-entry register file. It is a self-contained core: the bench or the system loads program and data through hierarchical access, releases reset, and the core runs until it retires a HLT. It provides partial operand bypassing and squashes wrong-path instructions on taken branches. Software must still place one independent instruction between a producer and its consumer.

## Interface
- No parameters. Memory depth is fixed at 1024 words; the register file is fixed at 32 x 32.
- clk1 — input, 1 bit. The single clock; all state updates on its rising edge.
- rst — input, 1 bit. Asynchronous, active-high reset.
- Visible internal state, part of the contract with hierarchical names fixed:
  - Reg[0:31] — 32-bit register file.
  - Mem[0:1023] — 32-bit memory.
  - PC — 32-bit; word index.
  - HALTED — 1 bit.
  - TAKEN_BRANCH — 1 bit.

## Operation
- Instruction format:
  - [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm.
  - imm is sign-extended to 32 bits.
- Register-register ALU ops, rd = rs op rt:
  - ADD 000000, SUB 000001, AND 000010, OR 000011.
  - SLT 000100: result 1 if signed rs < rt, else 0.
  - MUL 000101: low 32 bits of the product.
- Register-immediate ops, rt = rs op imm:
  - ADDI 001010, SUBI 001011.
  - SLTI 001100: signed compare.
- Memory ops:
  - LW 001000: rt = Mem[rs + imm].
  - SW 001001: Mem[rs + imm] = rt.
- Branches:
  - BNEQZ 001101: taken when rs != 0.
  - BEQZ 001110: taken when rs == 0.
  - Target = (branch PC + 1) + imm.
- HLT 111111.
- Undefined opcodes execute as NOP: no register, memory or PC side effect.
- Addresses are word indices; only bits [9:0] are used.
- Arithmetic is 32-bit two's complement and wraps.
- R0 always reads 0; writes to R0 are discarded.
- Operand read in ID, highest priority first:
  1. Result of the instruction currently in MEM (ALU result, or load data read combinationally from Mem).
  2. Result of the instruction in WB (write-through).
  3. Reg.
- A dependence at distance 1 (back-to-back) is not detected. The consumer reads the stale value, and software inserts a NOP there.
- Branches resolve in EX. When the branch is in the EX/MEM latch with its condition true:
  - IF fetches from the target.
  - The two younger instructions (in IF/ID and ID/EX) are converted to NOPs.
  - TAKEN_BRANCH is high for that cycle.
- HLT handling:
  - Once a HLT reaches ID, IF stops advancing PC and injects NOPs.
  - When the HLT reaches WB, HALTED is set to 1.
  - While HALTED = 1, no PC, Reg, Mem or latch updates occur until rst.
- Reset values:
  - PC = 0, HALTED = 0, TAKEN_BRANCH = 0.
  - All pipeline latches hold NOP with write-enables cleared.
  - Reg and Mem are not reset; their contents are preserved.

## Timing
- Instruction i fetched in cycle i has this schedule:
  - ID in cycle i+1.
  - EX in cycle i+2.
  - Mem access in cycle i+3.
  - Register write in cycle i+4.
- Throughput is one instruction per cycle; there are no stall cycles.
- Taken-branch penalty is 2 cycles.
- A store in MEM and a load of the same address in MEM in the same cycle cannot occur, because the pipeline has one MEM stage.
- A SW with a HLT older than it in the pipeline never writes: HLT blocks fetch at ID.
- rst asserted mid-execution: instructions in flight are discarded, writes of that cycle are suppressed, and fetch restarts at PC 0 after release.

## Structure
- Shared package pipe_mips32_pkg holds:
  - Opcode constants.
  - Instruction-type enum: RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT.
  - A NOP encoding: opcode 000011 with all register fields 0, i.e. OR R0,R0,R0.
- One sub-module, pipe_mips32_alu: combinational; inputs are op, a and b; output is 32 bits.
- The top level holds Reg, Mem, the pipeline latches, the bypass logic and the branch/halt control.

## Test plan
- Set Reg[k] = k for all k, then load this program at Mem[0..8], one instruction per word:
  - 0 — 2801000a
  - 1 — 28020014
  - 2 — 28030019
  - 3 — 0ce77800
  - 4 — 0ce77800
  - 5 — 00222000
  - 6 — 0ce77800
  - 7 — 00832800
  - 8 — fc000000
  - Pulse rst, then run 20 cycles.
  - Required: R1 = 10, R2 = 20, R3 = 25, R4 = 30, R5 = 55, HALTED = 1, R0 = 0.
- Distance-2 bypass: ADDI R1,R0,7; NOP; ADD R2,R1,R1; HLT → R2 = 14.
- Load/store: Mem[120] = 85.
  - LW R2,0(R1) with R1 = 120 preset; NOP; ADDI R2,R2,45; NOP; SW R2,1(R1); HLT.
  - Required: Mem[121] = 130.
- Taken branch: BEQZ R0 with imm = 2, followed by ADDI R9,R0,1 and ADDI R9,R0,2, then target ADDI R8,R0,5; HLT.
  - Required: R9 unchanged, R8 = 5, TAKEN_BRANCH pulses once.
- HALT freeze: a SW placed after HLT leaves Mem unchanged, and PC stays constant over 10 further cycles.
- Assert rst mid-program: PC = 0 immediately, HALTED = 0; after release the program reruns to the correct results.
